// File: rtl/prefetch_queue_ctrl_pkg.sv
// Shared fetch-path definitions: reset segment/IP constants, FSM states and the
// segmented-to-physical address helper that the RAM address path also uses.
package prefetch_queue_ctrl_pkg;

    localparam logic [15:0] DEF_RESET_CS = 16'hFFFF;
    localparam logic [15:0] DEF_RESET_IP = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // Physical address wraps at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

// File: rtl/prefetch_queue_ctrl_fifo.sv
// Byte FIFO for the prefetch queue; tracks the IP of the head byte as a sideband.
// Clear has priority over push and pop.
module prefetch_fifo
    import prefetch_queue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 6,
    parameter logic [15:0] RESET_IP = DEF_RESET_IP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] clear_ip,
    input  logic        push,
    input  logic [7:0]  push_byte,
    input  logic        pop,
    output logic [3:0]  count,
    output logic [7:0]  head_byte,
    output logic [15:0] head_ip
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop & (count != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_ip <= RESET_IP;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_ip <= clear_ip;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) begin
                rd_ptr  <= next_ptr(rd_ptr);
                head_ip <= head_ip + 16'd1;
            end
            count <= count + 4'(push) - 4'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= push_byte;
    end

    assign head_byte = (count != 4'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/prefetch_queue_ctrl.sv
// Instruction fetch controller: issues sequential ROM reads at CS:IP into a
// prefetch queue and streams bytes to the decoder; flush redirects fetch.
module prefetch_queue_ctrl
    import prefetch_queue_ctrl_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 6,
    parameter logic [15:0] RESET_CS    = DEF_RESET_CS,
    parameter logic [15:0] RESET_IP    = DEF_RESET_IP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] flush_cs,
    input  logic [15:0] flush_ip,
    input  logic        halt,
    output logic        rom_en,
    output logic [19:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        q_valid,
    output logic [7:0]  q_byte,
    output logic [15:0] q_ip,
    input  logic        q_ready,
    output logic [3:0]  q_count
);

    fetch_state_e state;
    logic [15:0]  fetch_cs;
    logic [15:0]  fetch_ip;
    logic         inflight;
    logic         discard;
    logic [4:0]   occupancy;
    logic         issue;
    logic         push;
    logic         pop;

    // Occupancy counts the outstanding read; a same-cycle pop earns no credit.
    assign occupancy = {1'b0, q_count} + {4'b0000, inflight};
    assign issue     = ~rst & (state == ST_RUN) & ~flush & (occupancy < 5'(QUEUE_DEPTH));
    assign rom_en    = issue;
    assign rom_addr  = issue ? phys_addr(fetch_cs, fetch_ip) : '0;

    assign push    = inflight & ~discard;
    assign pop     = q_valid & q_ready & ~flush;
    assign q_valid = (q_count != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            fetch_cs <= RESET_CS;
            fetch_ip <= RESET_IP;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= issue;
            discard  <= flush & inflight;
            if (flush) begin
                fetch_cs <= flush_cs;
                fetch_ip <= flush_ip;
            end else if (issue) begin
                fetch_ip <= fetch_ip + 16'd1;
            end
            case (state)
                ST_RUN:  if (halt && !flush) state <= ST_HALT;
                ST_HALT: if (!halt)          state <= ST_RUN;
                default:                     state <= ST_RUN;
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH    (QUEUE_DEPTH),
        .RESET_IP (RESET_IP)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .clear_ip  (flush_ip),
        .push      (push),
        .push_byte (rom_data),
        .pop       (pop),
        .count     (q_count),
        .head_byte (q_byte),
        .head_ip   (q_ip)
    );

endmodule

// File: tb/tb_prefetch_queue_ctrl.sv
// Self-checking bench: behavioural queue model plus ROM responder, randomized
// and directed stimulus, with literal pins on the key addresses and counts.
module tb_prefetch_queue_ctrl;

    localparam int unsigned DEPTH = 6;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] flush_cs;
    logic [15:0] flush_ip;
    logic        halt;
    logic        rom_en;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data;
    logic        q_valid;
    logic [7:0]  q_byte;
    logic [15:0] q_ip;
    logic        q_ready;
    logic [3:0]  q_count;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [7:0]  m_q[$];
    logic [15:0] m_qip, m_cs, m_ip;
    bit          m_inflight;
    logic [19:0] m_pend;
    bit          m_halted;

    prefetch_queue_ctrl #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_CS    (16'hFFFF),
        .RESET_IP    (16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .flush_cs (flush_cs),
        .flush_ip (flush_ip),
        .halt     (halt),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .q_valid  (q_valid),
        .q_byte   (q_byte),
        .q_ip     (q_ip),
        .q_ready  (q_ready),
        .q_count  (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_qip      = 16'h0000;
        m_cs       = 16'hFFFF;
        m_ip       = 16'h0000;
        m_inflight = 0;
        m_halted   = 0;
    endtask

    function automatic bit exp_en();
        return !m_halted && !flush && (m_q.size() + int'(m_inflight) < DEPTH);
    endfunction

    function automatic logic [19:0] exp_addr();
        return 20'(({4'h0, m_cs} << 4) + {4'h0, m_ip});
    endfunction

    // One clock: compare at negedge, advance model at posedge, ROM answers after.
    task automatic step();
        bit          e;
        bit          pop;
        logic        cap_en;
        logic [19:0] cap_addr;
        @(negedge clk);
        e = exp_en();
        chk("rom_en", rom_en, e);
        if (e) chk("rom_addr", rom_addr, exp_addr());
        chk("q_valid", q_valid, m_q.size() != 0);
        chk("q_count", q_count, m_q.size());
        if (m_q.size() != 0) chk("q_byte", q_byte, m_q[0]);
        chk("q_ip", q_ip, m_qip);
        cap_en   = rom_en;
        cap_addr = rom_addr;
        @(posedge clk);
        pop = (m_q.size() != 0) && q_ready;
        if (flush) begin
            m_q.delete();
            m_qip = flush_ip;
            m_cs  = flush_cs;
            m_ip  = flush_ip;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_qip++;
            end
            if (m_inflight) m_q.push_back(rom_fn(m_pend));
        end
        if (e) begin
            m_pend = exp_addr();
            m_ip++;
        end
        m_inflight = e;
        if (!m_halted) m_halted = halt && !flush;
        else           m_halted = halt;
        #1;
        rom_data = cap_en ? rom_fn(cap_addr) : 8'($urandom);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_flush(input logic [15:0] cs, input logic [15:0] ip);
        flush = 1'b1; flush_cs = cs; flush_ip = ip;
        step();
        flush = 1'b0;
        #1;
    endtask

    initial begin
        int guard;
        rst = 1'b1; flush = 1'b0; flush_cs = '0; flush_ip = '0;
        halt = 1'b0; q_ready = 1'b0; rom_data = 8'h00;
        #2;
        chk("reset_rom_en", rom_en, 1'b0);
        chk("reset_rom_addr", rom_addr, 20'h0);
        chk("reset_q_valid", q_valid, 1'b0);
        chk("reset_q_count", q_count, 4'd0);
        chk("reset_q_byte", q_byte, 8'h00);
        chk("reset_q_ip", q_ip, 16'h0000);
        #14;
        rst = 1'b0;
        model_reset();
        #1;
        chk("first_addr", rom_addr, 20'hFFFF0);

        // fill with no consumer, then stream with a consumer
        steps(12);
        #1;
        chk("full_count", q_count, 4'd6);
        chk("full_rom_en", rom_en, 1'b0);
        q_ready = 1'b1;
        steps(10);

        // flush while a read is in flight
        q_ready = 1'b0;
        guard = 0;
        while (!m_inflight && guard < 20) begin step(); guard++; end
        chk("inflight_seen", m_inflight, 1'b1);
        do_flush(16'h0100, 16'h0020);
        chk("flush_count", q_count, 4'd0);
        chk("flush_addr", rom_addr, 20'h01020);
        chk("flush_q_ip", q_ip, 16'h0020);
        steps(8);

        // IP wrap inside the segment
        do_flush(16'h0000, 16'hFFFE);
        chk("wrap_addr0", rom_addr, 20'h0FFFE);
        step(); #1;
        chk("wrap_addr1", rom_addr, 20'h0FFFF);
        step(); #1;
        chk("wrap_addr2", rom_addr, 20'h00000);
        steps(8);
        q_ready = 1'b1;
        steps(2);
        #1;
        chk("wrap_q_ip", q_ip, 16'h0000);

        // 20-bit physical wrap
        q_ready = 1'b0;
        do_flush(16'hFFFF, 16'h0010);
        chk("phys_wrap", rom_addr, 20'h00000);

        // halt and resume
        q_ready = 1'b1;
        steps(3);
        halt = 1'b1;
        steps(5);
        #1;
        chk("halt_rom_en", rom_en, 1'b0);
        halt = 1'b0;
        steps(5);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            flush = ($urandom_range(0, 19) == 0);
            flush_cs = 16'($urandom);
            flush_ip = 16'($urandom);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            q_ready = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step();
        end
        flush = 1'b0; halt = 1'b0;

        // asynchronous reset mid-stream
        q_ready = 1'b0;
        do_flush(16'h1234, 16'h0100);
        guard = 0;
        while (m_q.size() != 4 && guard < 20) begin step(); guard++; end
        chk("pre_reset_count", q_count, 4'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rom_en", rom_en, 1'b0);
        chk("async_rom_addr", rom_addr, 20'h0);
        chk("async_q_count", q_count, 4'd0);
        chk("async_q_valid", q_valid, 1'b0);
        chk("async_q_byte", q_byte, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rom_data = 8'hA5;
        #1;
        chk("restart_addr", rom_addr, 20'hFFFF0);
        steps(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
